// File: rtl/fft_stage_controller.sv
// In-place radix-2 DIT FFT sequencer: walks LOG2N stages of N/2 butterfly pairs each.
// Define FFT_CTRL_TIMEOUT_EN to abort a pass when the butterfly stalls in WAIT_BF.
module fft_stage_controller #(
   parameter int N              = 8,
   parameter int LOG2N          = 3,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             bf_start,
   input  logic             bf_done,
   output logic [LOG2N-1:0] addr_0,
   output logic [LOG2N-1:0] addr_1,
   output logic [LOG2N-2:0] tw_idx,
   output logic             wr_en,
   output logic [LOG2N-1:0] stage
);

   if (N != (1 << LOG2N) || LOG2N < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("fft_stage_controller: inconsistent N / LOG2N / TIMEOUT_CYCLES");
   end

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BF, WRITE, DONE} state_t;

   localparam logic [LOG2N-1:0] ONE    = LOG2N'(1);
   localparam logic [LOG2N-1:0] S_LAST = LOG2N'(LOG2N - 1);
   localparam logic [LOG2N-2:0] K_LAST = (LOG2N-1)'(N / 2 - 1);

   state_t           state_q, state_d;
   logic [LOG2N-1:0] s_q, s_d;
   logic [LOG2N-2:0] k_q, k_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             bf_start_q, bf_start_d;
   logic             wr_en_q, wr_en_d;
   logic [LOG2N-1:0] addr_0_q, addr_0_d;
   logic [LOG2N-1:0] addr_1_q, addr_1_d;
   logic [LOG2N-2:0] tw_idx_q, tw_idx_d;

`ifdef FFT_CTRL_TIMEOUT_EN
   localparam int            TO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   logic [TO_W-1:0] to_q, to_d;
   logic            err_q, err_d;
`endif

   // Upper leg: group base (grp * 2 * half) plus position inside the group.
   function automatic logic [LOG2N-1:0] leg0_addr(input logic [LOG2N-2:0] k,
                                                  input logic [LOG2N-1:0] s);
      logic [LOG2N-1:0] kk;
      logic [LOG2N-1:0] mask;
      kk   = {1'b0, k};
      mask = (ONE << s) - ONE;
      return ((kk >> s) << (s + ONE)) | (kk & mask);
   endfunction

   function automatic logic [LOG2N-2:0] tw_index(input logic [LOG2N-2:0] k,
                                                 input logic [LOG2N-1:0] s);
      logic [LOG2N-1:0] pos;
      pos = {1'b0, k} & ((ONE << s) - ONE);
      return (LOG2N-1)'(pos << (S_LAST - s));
   endfunction

   always_comb begin
      state_d  = state_q;
      s_d      = s_q;
      k_d      = k_q;
      addr_0_d = addr_0_q;
      addr_1_d = addr_1_q;
      tw_idx_d = tw_idx_q;
`ifdef FFT_CTRL_TIMEOUT_EN
      to_d     = to_q;
      err_d    = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               s_d     = '0;
               k_d     = '0;
               state_d = ISSUE;
`ifdef FFT_CTRL_TIMEOUT_EN
               err_d   = 1'b0;
`endif
            end
         end
         ISSUE: begin
            state_d = WAIT_BF;
`ifdef FFT_CTRL_TIMEOUT_EN
            to_d    = '0;
`endif
         end
         WAIT_BF: begin
            if (bf_done) begin
               state_d = WRITE;
`ifdef FFT_CTRL_TIMEOUT_EN
            end else if (to_q == TO_LAST) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               to_d    = to_q + TO_W'(1);
`endif
            end
         end
         WRITE: begin
            if (k_q != K_LAST) begin
               k_d     = k_q + (LOG2N-1)'(1);
               state_d = ISSUE;
            end else if (s_q != S_LAST) begin
               k_d     = '0;
               s_d     = s_q + ONE;
               state_d = ISSUE;
            end else begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from the next state so they register alongside it.
      busy_d     = (state_d != IDLE);
      bf_start_d = (state_d == ISSUE);
      wr_en_d    = (state_d == WRITE);
      done_d     = (state_d == DONE);
      if (state_d == ISSUE) begin
         addr_0_d = leg0_addr(k_d, s_d);
         addr_1_d = leg0_addr(k_d, s_d) + (ONE << s_d);
         tw_idx_d = tw_index(k_d, s_d);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         s_q        <= '0;
         k_q        <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         bf_start_q <= 1'b0;
         wr_en_q    <= 1'b0;
         addr_0_q   <= '0;
         addr_1_q   <= '0;
         tw_idx_q   <= '0;
`ifdef FFT_CTRL_TIMEOUT_EN
         to_q       <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         s_q        <= s_d;
         k_q        <= k_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         bf_start_q <= bf_start_d;
         wr_en_q    <= wr_en_d;
         addr_0_q   <= addr_0_d;
         addr_1_q   <= addr_1_d;
         tw_idx_q   <= tw_idx_d;
`ifdef FFT_CTRL_TIMEOUT_EN
         to_q       <= to_d;
         err_q      <= err_d;
`endif
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign bf_start = bf_start_q;
   assign wr_en    = wr_en_q;
   assign addr_0   = addr_0_q;
   assign addr_1   = addr_1_q;
   assign tw_idx   = tw_idx_q;
   assign stage    = s_q;
`ifdef FFT_CTRL_TIMEOUT_EN
   assign err      = err_q;
`else
   assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_fft_stage_controller.sv
// Directed bench for fft_stage_controller (N=8): address/twiddle order, pass latency,
// start handling, asynchronous reset abort and butterfly stall behaviour.
module tb_fft_stage_controller;

   logic       clk;
   logic       reset;
   logic       start;
   logic       busy, done, err, bf_start, bf_done, wr_en;
   logic [2:0] addr_0, addr_1, stage;
   logic [1:0] tw_idx;

   fft_stage_controller #(.N(8), .LOG2N(3), .TIMEOUT_CYCLES(16)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .bf_start (bf_start),
      .bf_done  (bf_done),
      .addr_0   (addr_0),
      .addr_1   (addr_1),
      .tw_idx   (tw_idx),
      .wr_en    (wr_en),
      .stage    (stage)
   );

   typedef struct {int a0; int a1; int tw; int st;} wr_t;

   int exp_a0 [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
   int exp_a1 [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
   int exp_tw [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

   int  n_tests = 0;
   int  n_fail  = 0;
   int  cyc     = 0;
   int  lat     = 1;
   bit  spur    = 1'b0;
   int  issue_cnt = 0;
   int  hold_idx  = -1;
   int  hold_lat  = 1;
   wr_t wq[$];
   int  dq[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (wr_en) wq.push_back('{int'(addr_0), int'(addr_1), int'(tw_idx), int'(stage)});
      if (done) dq.push_back(cyc);
   end

   // Butterfly model: bf_done high L cycles after bf_start, optional stray pulse in ISSUE.
   initial begin
      int l_use;
      bf_done = 1'b0;
      forever begin
         @(posedge clk);
         #3;
         if (bf_start) begin
            l_use = (issue_cnt == hold_idx) ? hold_lat : lat;
            issue_cnt++;
            if (spur) begin
               bf_done = 1'b1;
               @(posedge clk);
               #3 bf_done = 1'b0;
               repeat (l_use - 1) @(posedge clk);
            end else begin
               repeat (l_use) @(posedge clk);
            end
            #3 bf_done = 1'b1;
            @(posedge clk);
            #3 bf_done = 1'b0;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got stuck expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_err"}, err, 0);
      check({tag, "_bfs"}, bf_start, 0);
      check({tag, "_wr"}, wr_en, 0);
      check({tag, "_a0"}, addr_0, 0);
      check({tag, "_a1"}, addr_1, 0);
      check({tag, "_tw"}, tw_idx, 0);
      check({tag, "_stage"}, stage, 0);
   endtask

   // Runs npass back-to-back passes; exp_t is the start-to-done latency of one pass.
   task automatic run_pass(input int l, input bit sp, input bit nag, input bit probe,
                           input int npass, input int exp_t, input string tag);
      int c0;
      int budget;
      lat  = l;
      spur = sp;
      wq.delete();
      dq.delete();
      @(posedge clk);
      #2 start = 1'b1;
      c0 = cyc;
      @(posedge clk);
      #2 start = (npass > 1);
      check({tag, "_busy0"}, busy, 1);
      check({tag, "_err0"}, err, 0);
      budget = 0;
      while (dq.size() < npass && budget < 4000) begin
         if (nag) start = (cyc % 2 == 0);
         if (probe && (cyc - c0 == 60)) begin
            check({tag, "_hold_busy"}, busy, 1);
            check({tag, "_hold_err"}, err, 0);
            check({tag, "_hold_wr"}, wr_en, 0);
            check({tag, "_hold_a0"}, addr_0, 1);
            check({tag, "_hold_a1"}, addr_1, 3);
            check({tag, "_hold_tw"}, tw_idx, 2);
            check({tag, "_hold_stage"}, stage, 1);
         end
         @(posedge clk);
         #2;
         budget++;
      end
      start = 1'b0;
      if (dq.size() < npass) check({tag, "_done_timeout"}, dq.size(), npass);
      repeat (2) @(posedge clk);
      #2;
      check({tag, "_idle_busy"}, busy, 0);
      check({tag, "_ndone"}, dq.size(), npass);
      check({tag, "_nwr"}, wq.size(), 12 * npass);
      for (int p = 0; p < dq.size(); p++)
         check($sformatf("%s_lat%0d", tag, p), dq[p] - c0, p * (exp_t + 1) + exp_t);
      for (int i = 0; i < wq.size(); i++) begin
         check($sformatf("%s_w%0d_a0", tag, i), wq[i].a0, exp_a0[i % 12]);
         check($sformatf("%s_w%0d_a1", tag, i), wq[i].a1, exp_a1[i % 12]);
         check($sformatf("%s_w%0d_tw", tag, i), wq[i].tw, exp_tw[i % 12]);
         check($sformatf("%s_w%0d_st", tag, i), wq[i].st, (i % 12) / 4);
      end
   endtask

   initial begin
      int c0;
      start = 1'b0;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #2 check_all_zero("rst");
      reset = 1'b1;

      run_pass(1, 1'b0, 1'b0, 1'b0, 1, 37, "l1");
      run_pass(4, 1'b1, 1'b0, 1'b0, 1, 73, "l4spur");
      run_pass(2, 1'b0, 1'b1, 1'b0, 1, 49, "nag");
      run_pass(1, 1'b0, 1'b0, 1'b0, 2, 37, "held");

      // Asynchronous reset while stage 1 pair 5 is waiting on the butterfly.
      lat = 1;
      spur = 1'b0;
      wq.delete();
      dq.delete();
      @(posedge clk);
      #2 start = 1'b1;
      c0 = cyc;
      @(posedge clk);
      #2 start = 1'b0;
      while (cyc < c0 + 17) begin
         @(posedge clk);
         #2;
      end
      check("mid_stage", stage, 1);
      check("mid_busy", busy, 1);
      #2 reset = 1'b0;
      #1 check_all_zero("arst");
      repeat (10) @(posedge clk);
      #2;
      check("arst_nwr", wq.size(), 5);
      check("arst_ndone", dq.size(), 0);
      check("arst_busy", busy, 0);
      reset = 1'b1;
      run_pass(1, 1'b0, 1'b0, 1'b0, 1, 37, "post_rst");

`ifdef FFT_CTRL_TIMEOUT_EN
      // Pair 5 stalls longer than the timeout: abort with sticky err.
      hold_idx = issue_cnt + 5;
      hold_lat = 30;
      lat = 1;
      wq.delete();
      dq.delete();
      @(posedge clk);
      #2 start = 1'b1;
      c0 = cyc;
      @(posedge clk);
      #2 start = 1'b0;
      while (cyc < c0 + 32) begin
         @(posedge clk);
         #2;
      end
      check("to_pre_err", err, 0);
      check("to_pre_busy", busy, 1);
      @(posedge clk);
      #2;
      check("to_err", err, 1);
      check("to_busy", busy, 0);
      while (cyc < c0 + 60) begin
         @(posedge clk);
         #2;
      end
      check("to_err_sticky", err, 1);
      check("to_nwr", wq.size(), 5);
      check("to_ndone", dq.size(), 0);
      hold_idx = -1;
      run_pass(1, 1'b0, 1'b0, 1'b0, 1, 37, "after_to");
`else
      // Pair 5 stalls for 100 cycles; the controller simply waits.
      hold_idx = issue_cnt + 5;
      hold_lat = 100;
      run_pass(1, 1'b0, 1'b0, 1'b1, 1, 136, "stall");
      hold_idx = -1;
      check("stall_err", err, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fft_stage_controller.md
Name: fft_stage_controller

Overview:
- Sequences an in-place radix-2 decimation-in-time FFT of N points over log2(N) stages, one butterfly pair at a time.
- Drives pair addresses and the twiddle index into a shared butterfly unit, waits for its completion, then issues the in-place write-back strobe.
- Sits between the frame buffer, which holds bit-reversed input, and the butterfly or twiddle ROM datapath of the frame_fft_block.

Parameters:
- N, 8, FFT size; power of two, N >= 4.
- LOG2N, 3, log2(N); sets the stage count and address width.
- TIMEOUT_CYCLES, 16, maximum WAIT_BF dwell. Used only when FFT_CTRL_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request a full FFT pass; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the final stage's last write completes.
- err  out  1  sticky butterfly-timeout flag.
- bf_start  out  1  one-cycle pulse presenting a pair to the butterfly.
- bf_done  in  1  butterfly result ready; sampled only in WAIT_BF.
- addr_0  out  LOG2N  upper-leg (even) operand address.
- addr_1  out  LOG2N  lower-leg operand address.
- tw_idx  out  LOG2N-1  twiddle ROM index.
- wr_en  out  1  one-cycle write-back strobe to addr_0 and addr_1.
- stage  out  LOG2N  current stage number, 0..LOG2N-1 (debug).

Behaviour:
- All outputs are registered.
- Reset (reset=0, asynchronous) sets the state to IDLE and forces every output and internal counter to 0.
- Reset asserted mid-pass aborts the pass immediately: no further wr_en and no done.
- States: IDLE, ISSUE, WAIT_BF, WRITE, DONE.
  - IDLE: when start=1, clear the stage counter s and the pair counter k, clear err, and go to ISSUE. If start=0, stay in IDLE.
  - ISSUE (1 cycle): bf_start=1, with addr_0, addr_1 and tw_idx valid. Go to WAIT_BF.
  - WAIT_BF: hold the addresses and tw_idx. When bf_done=1, go to WRITE. A bf_done in the ISSUE cycle is ignored, so the butterfly's minimum latency is 1.
  - WRITE (1 cycle): wr_en=1 with the same addresses.
    - If k < N/2-1: k++ and go to ISSUE.
    - Else if s < LOG2N-1: k=0, s++ and go to ISSUE.
    - Else go to DONE.
  - DONE (1 cycle): done=1, then go to IDLE.
- Address generation, with half = 2^s, grp = k>>s and pos = k & (half-1):
  - addr_0 = grp*2*half + pos
  - addr_1 = addr_0 + half
  - tw_idx = pos << (LOG2N-1-s)
  - All arithmetic is unsigned and fits LOG2N bits; no wrap occurs.
- Throughput is (2+L) cycles per pair, where bf_done arrives L cycles after bf_start.
- Total latency: with start sampled in cycle c0, done is high in cycle c0+1+LOG2N*(N/2)*(2+L).
- start while busy is ignored; it is not queued.
- start held high across DONE re-triggers from IDLE on the cycle after DONE.
- bf_done outside WAIT_BF is ignored.
- Outputs of each transfer hold stable from ISSUE through WRITE.

Optional Feature:
- Macro: FFT_CTRL_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_BF.
  - If TIMEOUT_CYCLES cycles elapse without bf_done, set err=1 (sticky) and go to IDLE with no wr_en and no done.
  - err clears on the next accepted start.
- Undefined:
  - err is tied to 0.
  - WAIT_BF waits indefinitely.
  - No counter logic is present.

Test Plan:
- N=8, L=1, single start pulse -> pairs (0,1)(2,3)(4,5)(6,7), tw 0,0,0,0 -> (0,2)(1,3)(4,6)(5,7), tw 0,2,0,2 -> (0,4)(1,5)(2,6)(3,7), tw 0,1,2,3. Expect 12 wr_en pulses, done exactly 37 cycles after the start sample, then busy=0.
- N=8, L=4, with bf_done also pulsed during ISSUE cycles -> ISSUE-cycle pulses are ignored; per-pair period is 6; done at cycle 73.
- start pulsed repeatedly while busy -> no effect. start held high -> a second pass begins immediately after done, with the identical sequence.
- Reset driven low during stage 1 -> all outputs are 0 asynchronously and no done. After release, start -> full correct pass from stage 0.
- FFT_CTRL_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, bf_done withheld on pair 5 -> err=1 after 16 WAIT_BF cycles, return to IDLE, no wr_en for pair 5, no done. Next start clears err and the pass completes.
- FFT_CTRL_TIMEOUT_EN undefined, bf_done withheld for 100 cycles -> the controller remains in WAIT_BF with err=0 and resumes correctly when bf_done arrives.
